// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register between two CPU stages (EX/MEM in the MIPS32 core).
// Holds one instruction's control bits, ALU result, store operand and
// destination register. It has a valid/ready handshake, a flush that turns
// in-flight entries into bubbles, an optional 2-entry skid buffer that
// registers in_ready, and a saturating stall-cycle counter.
module pipe_stage_elastic #(
    parameter int XLEN   = 32,
    parameter int RN_W   = 5,
    parameter int CTRL_W = 3,
    parameter int SKID   = 1,
    parameter int CNT_W  = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [XLEN-1:0]   in_alu,
    input  logic [XLEN-1:0]   in_b,
    input  logic [RN_W-1:0]   in_rn,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [XLEN-1:0]   out_alu,
    output logic [XLEN-1:0]   out_b,
    output logic [RN_W-1:0]   out_rn,
    output logic [CNT_W-1:0]  stall_cycles
);

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic accept;
    logic fire;
    logic vld_p0;
    logic load_main_in;
    logic load_main_skid;
    logic load_skid;

    // Main entry (drives the outputs) and skid entry (second slot).
    logic [CTRL_W-1:0] main_ctrl_p0;
    logic [XLEN-1:0]   main_alu_p0;
    logic [XLEN-1:0]   main_b_p0;
    logic [RN_W-1:0]   main_rn_p0;
    logic [CTRL_W-1:0] skid_ctrl_p1;
    logic [XLEN-1:0]   skid_alu_p1;
    logic [XLEN-1:0]   skid_b_p1;
    logic [RN_W-1:0]   skid_rn_p1;

    assign accept = in_valid & in_ready;
    assign fire   = vld_p0 & out_ready;

    generate
        if (SKID != 0) begin : g_skid
            typedef enum logic [1:0] {
                S_EMPTY = 2'd0,
                S_ONE   = 2'd1,
                S_FULL  = 2'd2
            } state_t;

            state_t state;
            state_t state_nxt;
            logic   ready_q;

            // State register; in_ready is registered from the next state so
            // there is no combinational path from out_ready to in_ready.
            always_ff @(posedge clock) begin
                if (reset) begin
                    state   <= S_EMPTY;
                    ready_q <= 1'b1;
                end else begin
                    state   <= state_nxt;
                    ready_q <= (state_nxt != S_FULL);
                end
            end

            // Next-state: occupancy follows accept/fire; flush empties.
            always_comb begin
                state_nxt = state;
                if (flush) begin
                    state_nxt = S_EMPTY;
                end else begin
                    case (state)
                        S_EMPTY: if (accept) state_nxt = S_ONE;
                        S_ONE: begin
                            if (accept && !fire)      state_nxt = S_FULL;
                            else if (!accept && fire) state_nxt = S_EMPTY;
                        end
                        S_FULL:  if (fire) state_nxt = S_ONE;
                        default: state_nxt = S_EMPTY;
                    endcase
                end
            end

            // Output decode: which entry loads from where this cycle.
            always_comb begin
                load_main_in   = 1'b0;
                load_main_skid = 1'b0;
                load_skid      = 1'b0;
                if (!flush) begin
                    case (state)
                        S_EMPTY: load_main_in = accept;
                        S_ONE: begin
                            load_main_in = accept & fire;
                            load_skid    = accept & ~fire;
                        end
                        S_FULL:  load_main_skid = fire;
                        default: ;
                    endcase
                end
            end

            assign vld_p0   = (state != S_EMPTY);
            assign in_ready = ready_q;
        end else begin : g_single
            logic valid_q;

            // Single-entry valid bit: set on accept, cleared on drain or flush.
            always_ff @(posedge clock) begin
                if (reset)       valid_q <= 1'b0;
                else if (flush)  valid_q <= 1'b0;
                else if (accept) valid_q <= 1'b1;
                else if (fire)   valid_q <= 1'b0;
            end

            assign vld_p0         = valid_q;
            assign in_ready       = ~valid_q | out_ready;
            assign load_main_in   = accept & ~flush;
            assign load_main_skid = 1'b0;
            assign load_skid      = 1'b0;
        end
    endgenerate

    // Payload registers: main takes the input or the skid entry, skid takes the input.
    always_ff @(posedge clock) begin
        if (reset) begin
            main_ctrl_p0 <= '0;
            main_alu_p0  <= '0;
            main_b_p0    <= '0;
            main_rn_p0   <= '0;
            skid_ctrl_p1 <= '0;
            skid_alu_p1  <= '0;
            skid_b_p1    <= '0;
            skid_rn_p1   <= '0;
        end else begin
            if (load_main_in) begin
                main_ctrl_p0 <= in_ctrl;
                main_alu_p0  <= in_alu;
                main_b_p0    <= in_b;
                main_rn_p0   <= in_rn;
            end else if (load_main_skid) begin
                main_ctrl_p0 <= skid_ctrl_p1;
                main_alu_p0  <= skid_alu_p1;
                main_b_p0    <= skid_b_p1;
                main_rn_p0   <= skid_rn_p1;
            end
            if (load_skid) begin
                skid_ctrl_p1 <= in_ctrl;
                skid_alu_p1  <= in_alu;
                skid_b_p1    <= in_b;
                skid_rn_p1   <= in_rn;
            end
        end
    end

    // Stall counter: cycles where the head is valid but not taken.
    always_ff @(posedge clock) begin
        if (reset)                     stall_cycles <= '0;
        else if (vld_p0 & ~out_ready)  stall_cycles <= sat_inc(stall_cycles);
    end

    // A bubble carries all-zero control so it never writes state downstream.
    assign out_valid = vld_p0;
    assign out_ctrl  = vld_p0 ? main_ctrl_p0 : '0;
    assign out_alu   = main_alu_p0;
    assign out_b     = main_b_p0;
    assign out_rn    = main_rn_p0;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: three instances (skid buffer, single entry,
// skid buffer with a 4-bit counter) share one input stream and are compared
// each cycle against queue-based models of a FIFO of capacity 2 or 1.
module tb_pipe_stage_elastic;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [2:0]  in_ctrl;
    logic [31:0] in_alu;
    logic [31:0] in_b;
    logic [4:0]  in_rn;

    logic        ir_s1, ov_s1, ir_s0, ov_s0, ir_c4, ov_c4;
    logic [2:0]  oc_s1, oc_s0, oc_c4;
    logic [31:0] oa_s1, ob_s1, oa_s0, ob_s0, oa_c4, ob_c4;
    logic [4:0]  orn_s1, orn_s0, orn_c4;
    logic [31:0] sc_s1, sc_s0;
    logic [3:0]  sc_c4;

    always #5 clock = ~clock;

    pipe_stage_elastic #(.XLEN(32), .RN_W(5), .CTRL_W(3), .SKID(1), .CNT_W(32)) u_s1 (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(ir_s1), .in_ctrl(in_ctrl), .in_alu(in_alu),
        .in_b(in_b), .in_rn(in_rn), .out_valid(ov_s1), .out_ready(out_ready),
        .out_ctrl(oc_s1), .out_alu(oa_s1), .out_b(ob_s1), .out_rn(orn_s1),
        .stall_cycles(sc_s1));

    pipe_stage_elastic #(.XLEN(32), .RN_W(5), .CTRL_W(3), .SKID(0), .CNT_W(32)) u_s0 (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(ir_s0), .in_ctrl(in_ctrl), .in_alu(in_alu),
        .in_b(in_b), .in_rn(in_rn), .out_valid(ov_s0), .out_ready(out_ready),
        .out_ctrl(oc_s0), .out_alu(oa_s0), .out_b(ob_s0), .out_rn(orn_s0),
        .stall_cycles(sc_s0));

    pipe_stage_elastic #(.XLEN(32), .RN_W(5), .CTRL_W(3), .SKID(1), .CNT_W(4)) u_c4 (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(ir_c4), .in_ctrl(in_ctrl), .in_alu(in_alu),
        .in_b(in_b), .in_rn(in_rn), .out_valid(ov_c4), .out_ready(out_ready),
        .out_ctrl(oc_c4), .out_alu(oa_c4), .out_b(ob_c4), .out_rn(orn_c4),
        .stall_cycles(sc_c4));

    typedef struct packed {
        logic [2:0]  ctrl;
        logic [31:0] alu;
        logic [31:0] b;
        logic [4:0]  rn;
    } item_t;

    // Reference state: held instructions in order, counters, and whether the
    // payload registers still hold their post-reset zeros.
    item_t       q1[$];
    item_t       q0[$];
    logic        pz1, pz0;
    int unsigned cnt1, cnt0, cnt4;
    int          checks = 0;
    int          errors = 0;
    logic        acc1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_one(input string nm,
                             input logic [31:0] ir, input logic [31:0] ov,
                             input logic [31:0] oc, input logic [31:0] oa,
                             input logic [31:0] ob, input logic [31:0] orn,
                             input logic [31:0] sc,
                             input logic exp_ir, input item_t hq[$],
                             input logic pz, input logic [31:0] exp_sc);
        chk({nm, "_in_ready"}, ir, 32'(exp_ir));
        chk({nm, "_out_valid"}, ov, 32'(hq.size() > 0));
        if (hq.size() > 0) begin
            chk({nm, "_out_ctrl"}, oc, 32'(hq[0].ctrl));
            chk({nm, "_out_alu"},  oa, hq[0].alu);
            chk({nm, "_out_b"},    ob, hq[0].b);
            chk({nm, "_out_rn"},   orn, 32'(hq[0].rn));
        end else begin
            chk({nm, "_bubble_ctrl"}, oc, 32'd0);
            if (pz) begin
                chk({nm, "_rst_alu"}, oa, 32'd0);
                chk({nm, "_rst_b"},   ob, 32'd0);
                chk({nm, "_rst_rn"},  orn, 32'd0);
            end
        end
        chk({nm, "_stall_cycles"}, sc, exp_sc);
    endtask

    // One clock: check outputs against the model, then advance the model
    // with the handshake outcome seen at the rising edge.
    task automatic cycle();
        logic  r1, r0, a1, a0, f1, f0, st1, st0;
        item_t cur;
        #1;
        check_one("s1", 32'(ir_s1), 32'(ov_s1), 32'(oc_s1), oa_s1, ob_s1, 32'(orn_s1), sc_s1,
                  q1.size() < 2, q1, pz1, cnt1);
        check_one("s0", 32'(ir_s0), 32'(ov_s0), 32'(oc_s0), oa_s0, ob_s0, 32'(orn_s0), sc_s0,
                  (q0.size() == 0) || out_ready, q0, pz0, cnt0);
        check_one("c4", 32'(ir_c4), 32'(ov_c4), 32'(oc_c4), oa_c4, ob_c4, 32'(orn_c4), 32'(sc_c4),
                  q1.size() < 2, q1, pz1, cnt4);
        r1  = (q1.size() < 2);
        r0  = (q0.size() == 0) || out_ready;
        a1  = in_valid && r1;
        a0  = in_valid && r0;
        f1  = (q1.size() > 0) && out_ready;
        f0  = (q0.size() > 0) && out_ready;
        st1 = (q1.size() > 0) && !out_ready;
        st0 = (q0.size() > 0) && !out_ready;
        cur.ctrl = in_ctrl;
        cur.alu  = in_alu;
        cur.b    = in_b;
        cur.rn   = in_rn;
        acc1 = a1 && !reset && !flush;
        @(posedge clock);
        if (reset) begin
            q1.delete();
            q0.delete();
            pz1  = 1'b1;
            pz0  = 1'b1;
            cnt1 = 0;
            cnt0 = 0;
            cnt4 = 0;
        end else begin
            if (st1) begin
                if (cnt1 != 32'hFFFF_FFFF) cnt1++;
                if (cnt4 < 15) cnt4++;
            end
            if (st0 && cnt0 != 32'hFFFF_FFFF) cnt0++;
            if (flush) begin
                q1.delete();
                q0.delete();
            end else begin
                if (f1) void'(q1.pop_front());
                if (a1) begin q1.push_back(cur); pz1 = 1'b0; end
                if (f0) void'(q0.pop_front());
                if (a0) begin q0.push_back(cur); pz0 = 1'b0; end
            end
        end
        @(negedge clock);
    endtask

    task automatic tick(input logic v, input logic [31:0] a, input logic [2:0] c, input logic fl);
        in_valid = v;
        in_alu   = a;
        in_ctrl  = c;
        in_b     = $urandom;
        in_rn    = 5'($urandom);
        flush    = fl;
        cycle();
    endtask

    // Present one instruction until the skid-mode stage takes it (bounded).
    task automatic send(input logic [31:0] a, input logic [2:0] c, input int budget);
        int n;
        n = 0;
        do begin
            tick(1'b1, a, c, 1'b0);
            n++;
        end while (!acc1 && n < budget);
        chk("send_accepted", 32'(acc1), 32'd1);
    endtask

    // Reset for one cycle, with a handshake and flush presented that must be ignored.
    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b1;
        flush    = 1'b1;
        in_alu   = $urandom;
        cycle();
        reset    = 1'b0;
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_ctrl = '0; in_alu = '0; in_b = '0; in_rn = '0;
        q1.delete(); q0.delete();
        pz1 = 1'b1; pz0 = 1'b1; cnt1 = 0; cnt0 = 0; cnt4 = 0; acc1 = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        // Reset values.
        tick(1'b0, 32'h0, 3'd0, 1'b0);

        // Streaming with out_ready held high.
        out_ready = 1'b1;
        send(32'h10, 3'd1, 8);
        send(32'h20, 3'd2, 8);
        send(32'h30, 3'd3, 8);
        repeat (3) tick(1'b0, 32'h0, 3'd0, 1'b0);
        chk("stream_stall_zero", sc_s1, 32'd0);

        // Backpressure: two accepted, third held upstream, then drain.
        out_ready = 1'b0;
        send(32'hA, 3'd4, 8);
        send(32'hB, 3'd5, 8);
        repeat (3) tick(1'b1, 32'hC, 3'd6, 1'b0);
        chk("bp_in_ready_low", 32'(ir_s1), 32'd0);
        out_ready = 1'b1;
        send(32'hC, 3'd6, 8);
        repeat (4) tick(1'b0, 32'h0, 3'd0, 1'b0);

        // Flush while full, with a simultaneous accept attempt.
        out_ready = 1'b0;
        send(32'h61, 3'b111, 8);
        send(32'h62, 3'b111, 8);
        tick(1'b1, 32'h55, 3'b111, 1'b1);
        chk("flush_out_valid", 32'(ov_s1), 32'd0);
        out_ready = 1'b1;
        repeat (3) tick(1'b0, 32'h0, 3'd0, 1'b0);

        // Single-entry mode: in_ready follows out_ready while full.
        do_reset();
        out_ready = 1'b0;
        tick(1'b1, 32'h71, 3'd1, 1'b0);
        out_ready = 1'b1;
        tick(1'b1, 32'h72, 3'd2, 1'b0);
        out_ready = 1'b0;
        tick(1'b1, 32'h73, 3'd3, 1'b0);
        tick(1'b0, 32'h0, 3'd0, 1'b0);

        // Reset while full with seven stall cycles counted.
        do_reset();
        out_ready = 1'b0;
        tick(1'b1, 32'h81, 3'd7, 1'b0);
        tick(1'b1, 32'h82, 3'd7, 1'b0);
        repeat (6) tick(1'b0, 32'h0, 3'd0, 1'b0);
        chk("stall_before_reset", sc_s1, 32'd7);
        do_reset();
        tick(1'b0, 32'h0, 3'd0, 1'b0);

        // Counter saturation on the 4-bit instance.
        out_ready = 1'b0;
        tick(1'b1, 32'h91, 3'd2, 1'b0);
        repeat (20) tick(1'b0, 32'h0, 3'd0, 1'b0);
        chk("c4_saturated", 32'(sc_c4), 32'hF);

        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                out_ready = ($urandom_range(0, 2) != 0);
                tick(1'($urandom_range(0, 1)), $urandom, 3'($urandom_range(0, 7)),
                     ($urandom_range(0, 29) == 0));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_elastic.md
# pipe_stage_elastic

Parametrised, elastic successor to the fixed EX/MEM pipeline register for the MIPS32 pipeline CPU. It carries one instruction's control bits, ALU result, store operand and destination register number between two pipeline stages. It has a valid/ready handshake, a flush input that squashes in-flight instructions to bubbles, an optional 2-entry skid buffer that registers the upstream ready path, and a saturating stall-cycle counter. It is instantiated between EX and MEM, and is reusable for any stage boundary.

## Interface
- XLEN, 32: width of ALU result and store operand.
- RN_W, 5: destination register number width.
- CTRL_W, 3: control bit vector width (wreg, m2reg, wmem in MIPS32 use).
- SKID, 1: 1 = 2-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.
- CNT_W, 32: stall counter width.

- clock  in  1  Single clock. All state changes on the rising edge.
- reset  in  1  Synchronous, active-high reset.
- flush  in  1  Squash all held entries at this edge.
- in_valid  in  1  Upstream holds a valid instruction.
- in_ready  out  1  Stage can accept an instruction this cycle.
- in_ctrl  in  CTRL_W  Control bits.
- in_alu  in  XLEN  ALU result.
- in_b  in  XLEN  Store operand.
- in_rn  in  RN_W  Destination register.
- out_valid  out  1  Head entry is valid.
- out_ready  in  1  Downstream accepts the head entry.
- out_ctrl  out  CTRL_W  Head control bits, forced to 0 when out_valid=0.
- out_alu, out_b  out  XLEN  Head payload.
- out_rn  out  RN_W  Head destination register.
- stall_cycles  out  CNT_W  Count of cycles with out_valid=1 and out_ready=0.

## Operation
- Accept event = in_valid & in_ready. Fire event = out_valid & out_ready.
- Entries: main (drives outputs) and, when SKID=1, skid. Each entry holds ctrl, alu, b, rn and a valid bit.
- SKID=0:
  - in_ready = !main_valid | out_ready (combinational).
  - On accept, main loads the input and main_valid goes to 1.
  - On fire without accept, main_valid goes to 0.
- SKID=1 state machine. in_ready = (state != FULL), and is a registered output.
  - EMPTY: accept -> ONE, input loads main.
  - ONE, accept & fire -> ONE, input loads main.
  - ONE, accept & !fire -> FULL, input loads skid.
  - ONE, !accept & fire -> EMPTY.
  - ONE, no event -> hold.
  - FULL: fire -> ONE, skid moves to main. Otherwise hold.
- Ordering is strictly FIFO. No entry is duplicated or dropped except by flush or reset.
- Flush:
  - All valid bits clear at the edge and state goes to EMPTY.
  - An accept in the same cycle is discarded.
  - Payload registers are not cleared.
  - The counter is not affected.
- Reset:
  - Dominates flush.
  - Clears valid bits, all payload registers and stall_cycles.
  - State goes to EMPTY.
- out_ctrl = main_ctrl when main_valid=1, else 0. A bubble therefore never writes the register file or memory.
- Stall counter: increments by 1 when out_valid & !out_ready, saturates at all-ones.

## Timing
- Reset values:
  - out_valid=0, out_ctrl=0, out_alu=0, out_b=0, out_rn=0, stall_cycles=0.
  - in_ready=1 (both SKID modes).
  - Handshakes in the reset cycle are ignored.
- Latency: an input accepted at edge N is visible on the outputs after edge N (1 cycle) when the stage is empty or firing.
- Throughput: 1 instruction per cycle while out_ready=1, in both modes.
- SKID=1: in_ready deasserts the cycle after the second unconsumed accept. No combinational path exists from out_ready to in_ready.
- SKID=0: out_ready=1 on a full stage allows accept and fire in the same cycle.
- Flush in cycle N: out_valid=0 and out_ctrl=0 after edge N; in_ready=1 after edge N.
- Reset mid-stream: the next cycle looks exactly like post-reset, whatever the prior state.

## Test plan
- Streaming:
  - Stimulus: SKID=1, out_ready=1; feed alu=0x10,0x20,0x30 on consecutive cycles.
  - Required: outputs 0x10,0x20,0x30 on the following consecutive cycles; in_ready stays 1; stall_cycles=0.
- Backpressure:
  - Stimulus: SKID=1, out_ready=0; feed alu=0xA,0xB,0xC.
  - Required: 0xA and 0xB accepted; in_ready=0 from the cycle after the 0xB accept; 0xC is held upstream.
  - Stimulus continued: raise out_ready.
  - Required: outputs 0xA,0xB,0xC in order; stall_cycles equals the number of stalled cycles.
- Flush:
  - Stimulus: FULL state with ctrl=3'b111, flush=1 together with in_valid=1 (alu=0x55).
  - Required: next cycle out_valid=0, out_ctrl=0, in_ready=1; 0x55 never appears on the outputs.
- SKID=0 combinational ready:
  - Stimulus: stage full, out_ready toggles 1 then 0.
  - Required: in_ready follows out_ready in the same cycle; an accept and a fire occur in the same cycle.
- Reset mid-operation:
  - Stimulus: assert reset for one cycle while FULL with stall_cycles=7.
  - Required: all outputs 0 except in_ready=1; stall_cycles=0; the held entries are lost.
- Counter saturation:
  - Stimulus: CNT_W=4, out_valid=1, out_ready=0 for 20 cycles.
  - Required: stall_cycles stops at 4'hF.
